// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage core: arbitrates traps, memory freezes, hazard
// stalls and branch redirects into per-stage enables/flushes, plus watchdog and stall counter.
module pipeline_ctrl #(
    parameter int DRAIN_CYC = 2,
    parameter int MAX_STALL = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic             i_mem_busy,
    input  logic             i_trap,
    output logic             o_en_if,
    output logic             o_en_id,
    output logic             o_en_ex,
    output logic             o_en_mem,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_flush_ex_mem,
    output logic             o_trap_redirect,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {RUN, STALL, MEM_WAIT, DRAIN} state_t;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int RW = $clog2(MAX_STALL + 1);
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYC - 1);
    localparam logic [RW-1:0]    RUN_MAX    = RW'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t          state, state_nxt;
    logic [DW-1:0]   drain_cnt, drain_nxt;
    logic [RW-1:0]   run_cnt;
    logic            wd_inc;

    // Outputs respond in the same cycle; only sequencing state is registered.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        o_en_if         = 1'b1;
        o_en_id         = 1'b1;
        o_en_ex         = 1'b1;
        o_en_mem        = 1'b1;
        o_flush_if_id   = 1'b0;
        o_flush_id_ex   = 1'b0;
        o_flush_ex_mem  = 1'b0;
        o_trap_redirect = 1'b0;
        state_nxt       = state;
        drain_nxt       = drain_cnt;
        wd_inc          = 1'b0;

        if (!rst_n) begin
            {o_en_if, o_en_id, o_en_ex, o_en_mem}           = 4'b0000;
            {o_flush_if_id, o_flush_id_ex, o_flush_ex_mem}  = 3'b111;
            state_nxt = RUN;
        end else if (i_trap) begin
            {o_flush_if_id, o_flush_id_ex, o_flush_ex_mem}  = 3'b111;
            o_trap_redirect = 1'b1;
            state_nxt       = DRAIN;
            drain_nxt       = DRAIN_INIT;
        end else if (state == DRAIN) begin
            // Hazards and redirects are meaningless while IF/ID is being emptied.
            if (i_mem_busy) begin
                {o_en_if, o_en_id, o_en_ex, o_en_mem} = 4'b0000;
                wd_inc = 1'b1;
            end else begin
                o_en_if       = 1'b0;
                o_flush_if_id = 1'b1;
                if (drain_cnt == '0) state_nxt = RUN;
                else                 drain_nxt = drain_cnt - 1'b1;
            end
        end else if (i_mem_busy) begin
            {o_en_if, o_en_id, o_en_ex, o_en_mem} = 4'b0000;
            state_nxt = MEM_WAIT;
            wd_inc    = 1'b1;
        end else if (i_stall) begin
            o_en_if       = 1'b0;
            o_en_id       = 1'b0;
            o_flush_id_ex = 1'b1;
            state_nxt     = STALL;
            wd_inc        = 1'b1;
        end else begin
            o_flush_if_id = i_branch_taken;
            state_nxt     = RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            drain_cnt   <= '0;
            run_cnt     <= '0;
            o_timeout   <= 1'b0;
            o_stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (!wd_inc)                 run_cnt <= '0;
            else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
            if (wd_inc && run_cnt >= RUN_MAX - RW'(1))
                o_timeout <= 1'b1;
            if (!o_en_if && o_stall_cnt != CNT_MAX)
                o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

endmodule
